mealy_seq_detector: RTL and testbench
=====================================

MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, meaning pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning match-counter width.
REQ-003 The block SHALL have parameter PAT_RST, default 4'b1011 (PAT_W bits), meaning the pattern loaded at reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port P1, input, 1 bit: serial data bit.
REQ-007 The block SHALL have port P1_valid, input, 1 bit: P1 is sampled only when this is high.
REQ-008 The block SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 The block SHALL have port pat_load, input, 1 bit: strobe to load a new pattern.
REQ-010 The block SHALL have port pat_in, input, PAT_W bits: the new pattern, with the first-received bit at the MSB.
REQ-011 The block SHALL have port z, output, 1 bit: Mealy match flag.
REQ-012 The block SHALL have port match_cnt, output, CNT_W bits: the registered count of matches.
REQ-013 The block SHALL have port cnt_sat, output, 1 bit: high while match_cnt equals all-ones.

Function
REQ-014 State SHALL be: pattern register pat (PAT_W bits); history register hist (PAT_W-1 bits, newest bit at LSB); fill counter fill (0..PAT_W-1, saturating); match_cnt.
REQ-015 z SHALL be combinational, asserted in the same cycle the completing bit is presented: z = P1_valid & ~pat_load & ~rst & (fill == PAT_W-1) & ({hist, P1} == pat).
REQ-016 On an edge with P1_valid=1 and no match: hist <= {hist[PAT_W-3:0], P1}; fill <= min(fill+1, PAT_W-1).
REQ-017 On an edge with a match and overlap=1: hist shifts in P1 as in REQ-016; fill stays PAT_W-1, so a match can occur again as early as the next valid bit.
REQ-018 On an edge with a match and overlap=0: hist SHALL clear to 0 and fill <= 0; the next match needs PAT_W fresh valid bits.
REQ-019 On an edge with P1_valid=0: hist, fill and match_cnt SHALL hold, and z SHALL be 0.
REQ-020 On an edge with a match: match_cnt <= match_cnt+1, saturating at 2^CNT_W-1 with no wrap.
REQ-021 On an edge with pat_load=1: pat <= pat_in; hist <= 0; fill <= 0; match_cnt <= 0; the P1 bit in that cycle SHALL be discarded.
REQ-022 overlap SHALL be sampled only on match edges; changing it at any other time SHALL have no effect.
REQ-023 cnt_sat SHALL be derived combinationally from match_cnt.
REQ-024 An all-zeros or all-ones pattern SHALL be legal; with overlap=1 a run of identical bits SHALL match on every valid bit once fill saturates.

Reset
REQ-025 When rst=1 on an edge: pat <= PAT_RST; hist <= 0; fill <= 0; match_cnt <= 0. The resulting outputs SHALL be z=0 and cnt_sat=0.
REQ-026 rst SHALL take priority over pat_load and P1_valid.
REQ-027 z SHALL be forced 0 while rst=1.
REQ-028 Reset asserted mid-pattern SHALL discard the partial match; detection SHALL restart from empty history.

Verification
REQ-029 Bench SHALL cover: reset 2 cycles, idle inputs -> z=0, match_cnt=0, cnt_sat=0, pat=1011.
REQ-030 Bench SHALL cover: PAT_W=4, overlap=1, valid stream 1,0,1,1,0,1,1 -> z=1 during bit 4 and bit 7 only; match_cnt=2 after the final edge. The same stream with overlap=0 -> z=1 at bit 4 only; match_cnt=1.
REQ-031 Bench SHALL cover: stream 1,0 then P1_valid=0 for 3 cycles with P1 toggling, then 1,1 -> z=1 on the last bit; z=0 throughout the gap; match_cnt=1.
REQ-032 Bench SHALL cover: after bits 1,0,1, pulse pat_load with pat_in=0110 while P1=1 -> no match that cycle; then 0,1,1,0 -> z=1 on the final 0; match_cnt=1.
REQ-033 Bench SHALL cover: rst=1 in the cycle after 1,0,1, then 1 -> z=0; match_cnt=0.
REQ-034 Bench SHALL cover: CNT_W=2, overlap=1, pattern 1111, eight valid 1s -> matches on bits 4-8; match_cnt=3 with cnt_sat=1 after the 3rd match, holding at 3 afterwards.

Source files
------------

// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector with a runtime-loadable pattern,
// overlapping or non-overlapping detection, and a saturating match counter.
module mealy_seq_detector #(
  parameter int unsigned             PAT_W   = 4,
  parameter int unsigned             CNT_W   = 8,
  parameter logic [PAT_W-1:0]        PAT_RST = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             P1,
  input  logic             P1_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned      FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat;
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  pat_nxt;
  logic [PAT_W-2:0]  hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  // Candidate window: stored history with the bit presented this cycle at the LSB.
  logic [PAT_W-1:0]  window;
  logic              full;
  logic              match;

  // Match decode: a full history window equal to the pattern, masked by load and reset.
  always_comb begin
    window  = {hist, P1};
    full    = (fill == FILL_MAX);
    match   = P1_valid & ~pat_load & ~rst & full & (window == pat);
    z       = match;
    cnt_sat = &match_cnt;
  end

  // Next-state: pattern load wins over data; invalid cycles hold everything.
  always_comb begin
    pat_nxt  = pat;
    hist_nxt = hist;
    fill_nxt = fill;
    cnt_nxt  = match_cnt;

    if (pat_load) begin
      pat_nxt  = pat_in;
      hist_nxt = '0;
      fill_nxt = '0;
      cnt_nxt  = '0;
    end else if (P1_valid) begin
      if (match) begin
        if (match_cnt != '1) begin
          cnt_nxt = match_cnt + CNT_W'(1);
        end
        if (overlap) begin
          // fill is already saturated here, so leaving it alone keeps the window full
          hist_nxt = window[PAT_W-2:0];
        end else begin
          hist_nxt = '0;
          fill_nxt = '0;
        end
      end else begin
        hist_nxt = window[PAT_W-2:0];
        if (!full) begin
          fill_nxt = fill + FILL_W'(1);
        end
      end
    end
  end

  // State register with synchronous reset taking priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat       <= PAT_RST;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else begin
      pat       <= pat_nxt;
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      match_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench: table of vectors run through a scoreboard queue, plus a
// hand-written saturation sequence on a narrow-counter instance.
module tb_mealy_seq_detector;

  typedef struct {
    logic       rst;
    logic       v;
    logic       p1;
    logic       ov;
    logic       ld;
    logic [3:0] pin;
    logic       ez;
    logic [7:0] ecnt;
    logic       esat;
  } vec_t;

  logic       clk;
  logic       rst, P1, P1_valid, overlap, pat_load;
  logic [3:0] pat_in;
  logic       z;
  logic [7:0] match_cnt;
  logic       cnt_sat;

  logic       rst2, P1_2, P1_valid2, overlap2, pat_load2;
  logic [3:0] pat_in2;
  logic       z2;
  logic [1:0] match_cnt2;
  logic       cnt_sat2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  vec_t vecs[$];
  vec_t sb[$];

  mealy_seq_detector dut (
    .clk      (clk),
    .rst      (rst),
    .P1       (P1),
    .P1_valid (P1_valid),
    .overlap  (overlap),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .z        (z),
    .match_cnt(match_cnt),
    .cnt_sat  (cnt_sat)
  );

  mealy_seq_detector #(.PAT_W(4), .CNT_W(2), .PAT_RST(4'b1111)) dut2 (
    .clk      (clk),
    .rst      (rst2),
    .P1       (P1_2),
    .P1_valid (P1_valid2),
    .overlap  (overlap2),
    .pat_load (pat_load2),
    .pat_in   (pat_in2),
    .z        (z2),
    .match_cnt(match_cnt2),
    .cnt_sat  (cnt_sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic v, input logic p1,
                              input logic ov, input logic ld, input logic [3:0] pin,
                              input logic ez, input logic [7:0] ecnt);
    vec_t e;
    e.rst = r; e.v = v; e.p1 = p1; e.ov = ov; e.ld = ld; e.pin = pin;
    e.ez = ez; e.ecnt = ecnt; e.esat = (ecnt == 8'hFF);
    vecs.push_back(e);
  endfunction

  // data bit shorthand: valid, no load, no reset
  function automatic void bit_in(input logic p1, input logic ov, input logic ez,
                                 input logic [7:0] ecnt);
    add(1'b0, 1'b1, p1, ov, 1'b0, 4'b0000, ez, ecnt);
  endfunction

  function automatic void do_rst();
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd0);
  endfunction

  initial begin
    vec_t e;
    rst = 1'b1; P1 = 1'b0; P1_valid = 1'b0; overlap = 1'b0; pat_load = 1'b0; pat_in = '0;
    rst2 = 1'b1; P1_2 = 1'b0; P1_valid2 = 1'b0; overlap2 = 1'b1; pat_load2 = 1'b0; pat_in2 = '0;

    // reset two cycles, then idle
    do_rst(); do_rst();
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd0);

    // overlapping: 1,0,1,1,0,1,1 -> matches on bits 4 and 7
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0); bit_in(1, 1, 1, 1);
    bit_in(0, 1, 0, 1); bit_in(1, 1, 0, 1); bit_in(1, 1, 1, 2);
    do_rst();

    // non-overlapping: same stream -> match on bit 4 only
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 1, 1);
    bit_in(0, 0, 0, 1); bit_in(1, 0, 0, 1); bit_in(1, 0, 0, 1);
    do_rst();

    // valid gap with P1 toggling
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd0);
    bit_in(1, 1, 0, 0); bit_in(1, 1, 1, 1);
    do_rst();

    // load new pattern mid-stream, bit in load cycle discarded
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 8'd0);
    bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0); bit_in(1, 1, 0, 0); bit_in(0, 1, 1, 1);
    do_rst();

    // load in a cycle that would otherwise match also clears a non-zero count
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0); bit_in(1, 1, 1, 1);
    bit_in(0, 1, 0, 1); bit_in(1, 1, 0, 1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 8'd0);
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0); bit_in(1, 1, 1, 1);
    do_rst();

    // reset mid-pattern discards the partial match
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd0);
    bit_in(1, 1, 0, 0);

    // reset beats a simultaneous load: pattern must still be 1011
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 8'd0);
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0); bit_in(1, 1, 1, 1);
    do_rst();

    // overlap only matters on the match edge
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 1, 1, 1);
    bit_in(0, 0, 0, 1); bit_in(1, 0, 0, 1); bit_in(1, 1, 1, 2);

    @(posedge clk); #1;
    for (int unsigned i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].rst;
      P1_valid = vecs[i].v;
      P1       = vecs[i].p1;
      overlap  = vecs[i].ov;
      pat_load = vecs[i].ld;
      pat_in   = vecs[i].pin;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d_z", i), int'(z), int'(e.ez));
      @(posedge clk); #1;
      check($sformatf("vec%0d_cnt", i), int'(match_cnt), int'(e.ecnt));
      check($sformatf("vec%0d_sat", i), int'(cnt_sat), int'(e.esat));
    end
    rst = 1'b1; P1_valid = 1'b0;

    // narrow counter, pattern 1111, overlap: eight 1s match on bits 4..8, count saturates at 3
    @(posedge clk); #1;
    check("sat_rst_cnt", int'(match_cnt2), 0);
    check("sat_rst_sat", int'(cnt_sat2), 0);
    rst2 = 1'b0; P1_valid2 = 1'b1; P1_2 = 1'b1; overlap2 = 1'b1;
    for (int unsigned b = 1; b <= 8; b++) begin
      int unsigned exp_cnt;
      exp_cnt = (b < 4) ? 0 : ((b - 3 > 3) ? 3 : b - 3);
      @(negedge clk);
      check($sformatf("sat_bit%0d_z", b), int'(z2), (b >= 4) ? 1 : 0);
      @(posedge clk); #1;
      check($sformatf("sat_bit%0d_cnt", b), int'(match_cnt2), exp_cnt);
      check($sformatf("sat_bit%0d_sat", b), int'(cnt_sat2), (exp_cnt == 3) ? 1 : 0);
    end
    P1_valid2 = 1'b0;
    @(negedge clk);
    check("sat_idle_z", int'(z2), 0);
    @(posedge clk); #1;
    check("sat_hold_cnt", int'(match_cnt2), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
